// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw buttons and clear in, debounced move code, strobe and debug out.
// The slave side is the conditioner; the master side is whatever drives the buttons.
interface condicionador_botoes_if;
    logic [3:0] botoes;
    logic       limpa;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       multipla;
    logic [2:0] db_estado;
    logic [3:0] db_botoes_sync;

    modport slave (
        input  botoes,
        input  limpa,
        output jogada,
        output tem_jogada,
        output multipla,
        output db_estado,
        output db_botoes_sync
    );

    modport master (
        output botoes,
        output limpa,
        input  jogada,
        input  tem_jogada,
        input  multipla,
        input  db_estado,
        input  db_botoes_sync
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Synchronizes and debounces four push buttons, accepting only single-button presses and
// emitting one strobe per accepted press; multi-button presses raise a sticky flag instead.
module condicionador_botoes #(
    parameter int unsigned DEBOUNCE_CYCLES = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    condicionador_botoes_if.slave  bus
);

    typedef enum logic [2:0] {
        StOcioso      = 3'b000,
        StFiltraPress = 3'b001,
        StRegistra    = 3'b010,
        StEsperaSolta = 3'b011,
        StFiltraSolta = 3'b100
    } state_e;

    localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] jogada_q, jogada_d;
    logic       multipla_q, multipla_d;
    logic       cand_onehot;
    logic       cnt_last;

    assign cand_onehot = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);
    assign cnt_last    = (cnt_q == CntLast);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StOcioso;
            sync1_q    <= 4'd0;
            sync2_q    <= 4'd0;
            cand_q     <= 4'd0;
            cnt_q      <= 8'd0;
            jogada_q   <= 4'd0;
            multipla_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= bus.botoes;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            jogada_q   <= jogada_d;
            multipla_q <= multipla_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        // limpa is the default; a load or a set below overrides it in the same cycle
        jogada_d   = bus.limpa ? 4'd0 : jogada_q;
        multipla_d = bus.limpa ? 1'b0 : multipla_q;

        case (state_q)
            StOcioso: begin
                if (sync2_q != 4'd0) begin
                    state_d = StFiltraPress;
                    cand_d  = sync2_q;
                    cnt_d   = 8'd1;
                end
            end
            StFiltraPress: begin
                if (sync2_q == 4'd0) begin
                    state_d = StOcioso;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = 8'd1;
                end else if (cnt_last) begin
                    if (cand_onehot) begin
                        state_d  = StRegistra;
                        jogada_d = cand_q;
                    end else begin
                        state_d    = StEsperaSolta;
                        multipla_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRegistra: begin
                multipla_d = 1'b0;
                state_d    = StEsperaSolta;
            end
            StEsperaSolta: begin
                if (sync2_q == 4'd0) begin
                    state_d = StFiltraSolta;
                    cnt_d   = 8'd1;
                end
            end
            StFiltraSolta: begin
                if (sync2_q != 4'd0) begin
                    state_d = StEsperaSolta;
                end else if (cnt_last) begin
                    state_d = StOcioso;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StOcioso;
        endcase
    end

    assign bus.jogada         = jogada_q;
    assign bus.tem_jogada     = (state_q == StRegistra);
    assign bus.multipla       = multipla_q;
    assign bus.db_estado      = state_q;
    assign bus.db_botoes_sync = sync2_q;

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input conditioning stage placed directly upstream of the game datapath/control (circuito_exp*); it consumes the raw `botoes` pins and produces the `jogada` code and `tem_jogada` strobe that the game circuit uses.
- Synchronizes the 4 asynchronous buttons, then debounces both press and release.
- Accepts only single-button (one-hot) presses and emits exactly one 1-cycle strobe per accepted press.
- Flags multi-button presses so the game does not register a bogus move.

Parameters:
DEBOUNCE_CYCLES, 5, consecutive stable synchronized cycles required to accept a press or a release (legal range 2..255; 5 ms at the 1 kHz board clock).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clock edge when 0)
botoes  input  4  raw asynchronous button levels, 1 = pressed
limpa  input  1  synchronous clear of jogada and multipla, from the game control unit
jogada  output  4  registered one-hot code of the last accepted press, 0000 when none
tem_jogada  output  1  one-cycle strobe: new jogada accepted this cycle
multipla  output  1  sticky flag: last debounced press had 0 or more than 1 button
db_estado  output  3  current FSM state encoding
db_botoes_sync  output  4  2-FF synchronizer output, for debug

Behaviour:
- Synchronizer: 2 flip-flop stages per bit (`sync1` -> `sync2`). All FSM decisions use `sync2`; `db_botoes_sync` = `sync2`.
- Candidate register `cand[3:0]` and counter `cnt` (8 bits) are internal.
- Reset (reset=0 at an edge): state=OCIOSO, sync regs=0, cand=0, cnt=0, jogada=0000, tem_jogada=0, multipla=0, db_estado=000.
- Reset takes effect from any state mid-operation, and no strobe is produced in the cycle after a reset.
- FSM states (db_estado encoding):
  - OCIOSO=000: if sync2!=0 -> FILTRA_PRESS with cand<=sync2, cnt<=1.
  - FILTRA_PRESS=001:
    - sync2==0 -> OCIOSO.
    - sync2!=0 and sync2!=cand -> stay; cand<=sync2, cnt<=1 (restart).
    - sync2==cand and cnt==DEBOUNCE_CYCLES-1: cand one-hot -> REGISTRA and jogada<=cand; otherwise -> ESPERA_SOLTA with multipla<=1 and jogada unchanged.
    - otherwise cnt<=cnt+1.
  - REGISTRA=010: exactly one cycle; tem_jogada=1 only in this state (Moore); multipla<=0; -> ESPERA_SOLTA unconditionally.
  - ESPERA_SOLTA=011: if sync2==0 -> FILTRA_SOLTA with cnt<=1; else stay.
  - FILTRA_SOLTA=100:
    - sync2!=0 -> ESPERA_SOLTA (bounce, no new strobe).
    - cnt==DEBOUNCE_CYCLES-1 -> OCIOSO.
    - otherwise cnt<=cnt+1.
  - Unused encodings 101..111 -> OCIOSO.
- Latency: a raw press held stable from edge 0 produces tem_jogada=1 during the cycle after edge DEBOUNCE_CYCLES+2 (edge 7 for the default). `jogada` updates on that same edge.
- A new press is accepted only after a debounced full release. A held button therefore never produces a second strobe.
- Changing which button is held while in ESPERA_SOLTA is ignored until a full release.
- limpa=1 at an edge: jogada<=0000, multipla<=0; the FSM is unaffected.
- limpa coinciding with the FILTRA_PRESS->REGISTRA transition: the load wins, so jogada<=cand and the strobe still occurs.
- limpa coinciding with setting multipla: set wins.
- `jogada` holds its value indefinitely between accepted presses.

Test Plan:
- Reset, then botoes=0000 for 20 cycles -> jogada=0000, tem_jogada never 1, db_estado=000, multipla=0.
- botoes=0010 clean for 20 cycles then 0000 -> tem_jogada high exactly 1 cycle, 7 edges after the press (D=5); jogada=0010 held after release; db_estado returns to 000 ≥5 cycles after release.
- botoes=0100 with bounces 0100/0000/0100 every 2 cycles for 10 cycles, then stable 15 cycles -> exactly one strobe, jogada=0100, strobe 7 edges after the start of the stable run.
- botoes=1000 held 10000 cycles, release bouncing 3 times, then a second press of 0001 -> 1 strobe for 1000, then 1 strobe for 0001; jogada=0001.
- botoes=0011 held 20 cycles -> no strobe, multipla=1, jogada keeps its previous value. Release, then press 0001 -> strobe, multipla=0.
- reset=0 for 1 cycle while in FILTRA_PRESS, and separately limpa=1 after a press -> FSM=000 with no strobe; limpa clears jogada to 0000 and multipla to 0.
